nand_page_sequencer: RTL and testbench

Host-side command sequencer that sits directly upstream of nand_master and drives its cmd_in/activate/data_in port while watching busy/data_out. Two operations are offered: INIT and READ. INIT runs the power-up sequence (controller reset, chip enable, NAND reset, read ID), then captures the ID bytes. READ loads one page into the controller buffer and streams it out byte-by-byte on a valid/ready interface. This replaces hand-sequenced activate pulses with a single request/done handshake.

---
 rtl/nand_seq_pkg.sv | 24 ++
 rtl/nand_cmd_issuer.sv | 84 ++++++++
 rtl/nand_page_sequencer.sv | 154 +++++++++++++++
 tb/tb_nand_page_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND page sequencer: nand_master command codes,
// the sequencer state enum and the primitive request record.
package nand_seq_pkg;

  localparam logic [5:0] M_RESET               = 6'h01;
  localparam logic [5:0] M_NAND_RESET          = 6'h04;
  localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
  localparam logic [5:0] M_NAND_READ           = 6'h09;
  localparam logic [5:0] MI_GET_STATUS         = 6'h0D;
  localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
  localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
  localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
  localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_GUARD, S_WAITB, S_CAPT, S_STREAM, S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [5:0] cmd;
    logic [7:0] data;
  } nm_req_t;

endpackage

// File: rtl/nand_cmd_issuer.sv
// One nand_master primitive: wait not-busy, one-cycle activate, two guard
// cycles, wait not-busy; a 16-bit busy-wait timer aborts a stuck controller.
module nand_cmd_issuer
  import nand_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  nm_req_t    req,
  output logic       done,
  output logic       timeout,
  output logic [5:0] nm_cmd,
  output logic [7:0] nm_data,
  output logic       nm_activate,
  input  logic       nm_busy
);

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  seq_state_e  state, state_nx;
  nm_req_t     req_q;
  logic [15:0] tmr;
  logic        guard_last;
  logic        waiting, expired;

  assign waiting = (state == S_ISSUE || state == S_WAITB) && nm_busy;
  assign expired = waiting && (tmr == TMR_LAST);
  assign nm_cmd  = req_q.cmd;
  assign nm_data = req_q.data;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // activate is gated by nm_busy combinationally so it can never overlap busy
  always_comb begin
    state_nx    = state;
    nm_activate = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (expired) begin
                 timeout  = 1'b1;
                 state_nx = S_IDLE;
               end else if (!nm_busy) begin
                 nm_activate = 1'b1;
                 state_nx    = S_GUARD;
               end
      S_GUARD: if (guard_last) state_nx = S_WAITB;
      S_WAITB: if (expired) begin
                 timeout  = 1'b1;
                 state_nx = S_IDLE;
               end else if (!nm_busy) begin
                 done     = 1'b1;
                 state_nx = S_IDLE;
               end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_q      <= '0;
      tmr        <= '0;
      guard_last <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        req_q <= req;
        tmr   <= '0;
      end
      if (nm_activate) begin
        tmr        <= '0;
        guard_last <= 1'b0;
      end else if (state == S_GUARD) begin
        guard_last <= 1'b1;
      end else if (waiting && !expired) begin
        tmr <= tmr + 16'd1;
      end
    end

endmodule

// File: rtl/nand_page_sequencer.sv
// INIT / READ command sequencer in front of nand_master. Optional status
// check after the page load is enabled with NAND_SEQ_STATUS_CHECK_EN.
module nand_page_sequencer
  import nand_seq_pkg::*;
#(
  parameter int          PAGE_BYTES     = 528,
  parameter int          ID_BYTES       = 5,
  parameter logic [7:0]  CE_SEL         = 8'h00,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_req,
  input  logic                  op_sel,
  output logic                  op_busy,
  output logic                  op_done,
  output logic                  op_err,
  output logic [8*ID_BYTES-1:0] id_bytes,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [5:0]            nm_cmd,
  output logic [7:0]            nm_data,
  output logic                  nm_activate,
  input  logic                  nm_busy,
  input  logic [7:0]            nm_dout
);

  localparam int CW = $clog2(PAGE_BYTES + 1);
  localparam logic [2:0] INIT_LOOP = 3'd4;
`ifdef NAND_SEQ_STATUS_CHECK_EN
  localparam logic [2:0] READ_LOOP = 3'd4;
`else
  localparam logic [2:0] READ_LOOP = 3'd3;
`endif

  seq_state_e    state, state_nx;
  logic          is_read, err_q;
  logic [2:0]    step;
  logic [CW-1:0] cnt;
  logic          in_loop, at_status, last_id, last_byte;
  logic          iss_start, iss_done, iss_timeout;
  nm_req_t       req;

  // step parks at the loop index; cnt then counts ID or page bytes
  assign in_loop   = step == (is_read ? READ_LOOP : INIT_LOOP);
  assign last_id   = cnt == CW'(ID_BYTES - 1);
  assign last_byte = cnt == CW'(PAGE_BYTES - 1);
`ifdef NAND_SEQ_STATUS_CHECK_EN
  assign at_status = is_read && step == 3'd2;
`else
  assign at_status = 1'b0;
`endif

  assign op_busy = state != S_IDLE;
  assign op_done = state == S_DONE;
  assign op_err  = op_done && err_q;

  always_comb begin
    req = '0;
    if (!is_read)
      case (step)
        3'd0:    req.cmd = M_RESET;
        3'd1:    begin req.cmd = MI_CHIP_ENABLE; req.data = CE_SEL; end
        3'd2:    req.cmd = M_NAND_RESET;
        3'd3:    req.cmd = M_NAND_READ_ID;
        default: req.cmd = MI_GET_ID_BYTE;
      endcase
    else
      case (step)
        3'd0:    req.cmd = MI_RESET_INDEX;
        3'd1:    req.cmd = M_NAND_READ;
`ifdef NAND_SEQ_STATUS_CHECK_EN
        3'd2:    req.cmd = MI_GET_STATUS;
        3'd3:    req.cmd = MI_RESET_INDEX;
`else
        3'd2:    req.cmd = MI_RESET_INDEX;
`endif
        default: req.cmd = MI_GET_DATA_PAGE_BYTE;
      endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx  = state;
    iss_start = 1'b0;
    case (state)
      S_IDLE:   if (op_req) state_nx = S_ISSUE;
      S_ISSUE:  begin iss_start = 1'b1; state_nx = S_WAITB; end
      S_WAITB:  if (iss_timeout)   state_nx = S_DONE;
                else if (iss_done) state_nx = (in_loop || at_status) ? S_CAPT : S_ISSUE;
      S_CAPT:   if (at_status)     state_nx = nm_dout[0] ? S_DONE : S_ISSUE;
                else if (is_read)  state_nx = S_STREAM;
                else               state_nx = last_id ? S_DONE : S_ISSUE;
      S_STREAM: if (m_ready) state_nx = last_byte ? S_DONE : S_ISSUE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      is_read  <= 1'b0;
      err_q    <= 1'b0;
      step     <= '0;
      cnt      <= '0;
      id_bytes <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (op_req) begin
                    is_read <= op_sel;
                    err_q   <= 1'b0;
                    step    <= '0;
                    cnt     <= '0;
                  end
        S_WAITB:  if (iss_timeout) err_q <= 1'b1;
                  else if (iss_done && !in_loop && !at_status) step <= step + 3'd1;
        S_CAPT:   if (at_status) begin
                    err_q <= nm_dout[0];
                    step  <= step + 3'd1;
                  end else if (is_read) begin
                    m_data  <= nm_dout;
                    m_valid <= 1'b1;
                  end else begin
                    id_bytes[{cnt[2:0], 3'b000} +: 8] <= nm_dout;
                    cnt <= last_id ? '0 : cnt + CW'(1);
                  end
        S_STREAM: if (m_ready) begin
                    m_valid <= 1'b0;
                    cnt     <= last_byte ? '0 : cnt + CW'(1);
                  end
        default:  ;
      endcase
    end

  nand_cmd_issuer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_issuer (
    .clk         (clk),
    .rst         (reset),
    .start       (iss_start),
    .req         (req),
    .done        (iss_done),
    .timeout     (iss_timeout),
    .nm_cmd      (nm_cmd),
    .nm_data     (nm_data),
    .nm_activate (nm_activate),
    .nm_busy     (nm_busy)
  );

endmodule

// File: tb/tb_nand_page_sequencer.sv
// Bench for nand_page_sequencer: behavioural nand_master/flash responder with
// random busy latency, random page data and random stream back-pressure.
module tb_nand_page_sequencer;
  import nand_seq_pkg::*;

  localparam int         PAGE = 528;
  localparam int         IDN  = 5;
  localparam int         TMO  = 100;
  localparam logic [7:0] CE   = 8'h03;
`ifdef NAND_SEQ_STATUS_CHECK_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, op_req = 1'b0, op_sel = 1'b0;
  logic op_busy, op_done, op_err, m_valid, nm_activate;
  logic m_ready = 1'b1, nm_busy = 1'b0;
  logic [8*IDN-1:0] id_bytes;
  logic [7:0] m_data, nm_data;
  logic [7:0] nm_dout = 8'h00;
  logic [5:0] nm_cmd;

  always #5 clk = ~clk;

  nand_page_sequencer #(.PAGE_BYTES(PAGE), .ID_BYTES(IDN), .CE_SEL(CE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .op_req(op_req), .op_sel(op_sel), .op_busy(op_busy),
    .op_done(op_done), .op_err(op_err), .id_bytes(id_bytes), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .nm_cmd(nm_cmd), .nm_data(nm_data),
    .nm_activate(nm_activate), .nm_busy(nm_busy), .nm_dout(nm_dout)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flash / controller model state
  logic [7:0]  id_rom [IDN];
  logic [7:0]  page [PAGE];
  logic [13:0] log_q [$];
  int  id_ptr = 0, pg_ptr = 0, busy_left = 0, cyc = 0;
  int  act_cnt = 0, rx_cnt = 0, rx_base = 0, last_hs_cyc = 0, done_cyc = 0, act_cyc = 0;
  int  rdy_mode = 0;
  bit  pend = 0, prev_act = 0, stuck = 0, stalled = 0;
  logic [5:0] pcmd = '0;
  logic [7:0] held = '0;

  // responder + stream monitor; inputs change on the falling edge only
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      pend = 0; nm_busy = 1'b0; busy_left = 0; stalled = 0; prev_act = 0;
    end else begin
      if (op_done) done_cyc = cyc;
      if (nm_activate) begin
        act_cnt++; act_cyc = cyc;
        log_q.push_back({nm_cmd, nm_data});
        chk("act_while_busy", nm_busy, 1'b0);
        chk("act_width", prev_act, 1'b0);
        pcmd = nm_cmd; pend = 1;
      end else if (pend) begin
        pend = 0; nm_busy = 1'b1; busy_left = $urandom_range(1, 5);
        case (pcmd)
          M_NAND_READ_ID:        id_ptr = 0;
          MI_GET_ID_BYTE:        begin nm_dout = id_rom[id_ptr % IDN]; id_ptr++; end
          MI_RESET_INDEX:        pg_ptr = 0;
          MI_GET_DATA_PAGE_BYTE: begin nm_dout = page[pg_ptr % PAGE]; pg_ptr++; end
          MI_GET_STATUS:         nm_dout = 8'h00;
          default: ;
        endcase
      end else if (nm_busy && !stuck) begin
        busy_left--;
        if (busy_left <= 0) nm_busy = 1'b0;
      end
      prev_act = nm_activate;
      if (stalled) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, held);
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      stalled = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) begin
        chk("stream_in_range", (rx_cnt - rx_base) < PAGE, 1'b1);
        chk("stream_byte", m_data, page[(rx_cnt - rx_base) % PAGE]);
        rx_cnt++; last_hs_cyc = cyc;
      end
    end
  end

  task automatic start_op(input logic sel);
    @(negedge clk); op_sel = sel; op_req = 1'b1;
    @(negedge clk); op_req = 1'b0;
    chk("accept_busy", op_busy, 1'b1);
  endtask

  task automatic wait_done(input int budget, output logic err);
    bit seen = 0;
    err = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (op_done) begin seen = 1; err = op_err; break; end
    end
    chk("done_seen", seen, 1'b1);
  endtask

  task automatic read_check(input int mode, input bit poke);
    logic [13:0] exp_pre [PRE];
    logic err;
    int lb;
`ifdef NAND_SEQ_STATUS_CHECK_EN
    exp_pre = '{{MI_RESET_INDEX, 8'h00}, {M_NAND_READ, 8'h00}, {MI_GET_STATUS, 8'h00}, {MI_RESET_INDEX, 8'h00}};
`else
    exp_pre = '{{MI_RESET_INDEX, 8'h00}, {M_NAND_READ, 8'h00}, {MI_RESET_INDEX, 8'h00}};
`endif
    foreach (page[i]) page[i] = 8'($urandom);
    rdy_mode = mode; rx_base = rx_cnt; lb = log_q.size();
    start_op(1'b1);
    if (poke) begin
      repeat (40) @(negedge clk);
      op_sel = 1'b0; op_req = 1'b1;
      @(negedge clk); op_req = 1'b0;
    end
    wait_done(30000, err);
    @(negedge clk);
    chk("read_err", err, 1'b0);
    chk("read_count", rx_cnt - rx_base, PAGE);
    chk("read_ncmd", log_q.size() - lb, PRE + PAGE);
    for (int i = 0; i < PRE; i++) chk("read_cmd", log_q[lb + i], exp_pre[i]);
    chk("done_after_last", done_cyc - last_hs_cyc, 1);
    chk("idle_after_read", op_busy, 1'b0);
  endtask

  task automatic init_check(input string tag);
    logic [13:0] exp_cmd [4 + IDN];
    logic err;
    int ab, lb;
    exp_cmd[0] = {M_RESET, 8'h00};
    exp_cmd[1] = {MI_CHIP_ENABLE, CE};
    exp_cmd[2] = {M_NAND_RESET, 8'h00};
    exp_cmd[3] = {M_NAND_READ_ID, 8'h00};
    for (int i = 0; i < IDN; i++) exp_cmd[4 + i] = {MI_GET_ID_BYTE, 8'h00};
    ab = act_cnt; lb = log_q.size();
    start_op(1'b0);
    wait_done(4000, err);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_id16"}, id_bytes[15:0], 16'h76EC);
    chk({tag, "_id"}, id_bytes, 40'h743F5A76EC);
    chk({tag, "_acts"}, act_cnt - ab, 4 + IDN);
    for (int i = 0; i < 4 + IDN; i++) chk({tag, "_cmd"}, log_q[lb + i], exp_cmd[i]);
  endtask

  initial begin
    logic err;
    bit in_win;
    id_rom = '{8'hEC, 8'h76, 8'h5A, 8'h3F, 8'h74};
    foreach (page[i]) page[i] = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_op_busy", op_busy, 1'b0);
    chk("rst_op_done", op_done, 1'b0);
    chk("rst_op_err", op_err, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_activate", nm_activate, 1'b0);
    chk("rst_nm_cmd", nm_cmd, 6'h00);
    chk("rst_nm_data", nm_data, 8'h00);
    chk("rst_id_bytes", id_bytes, 40'h0);
    @(negedge clk); reset = 1'b0;

    init_check("init");
    read_check(0, 1'b0);
    read_check(1, 1'b0);
    read_check(2, 1'b1);

    // reset in the middle of a READ, then a clean READ from byte 0
    foreach (page[i]) page[i] = 8'($urandom);
    rdy_mode = 0; rx_base = rx_cnt;
    start_op(1'b1);
    for (int i = 0; i < 3000 && (rx_cnt - rx_base) < 11; i++) @(negedge clk);
    chk("mid_reached_byte10", (rx_cnt - rx_base) >= 11, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", op_busy, 1'b0);
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_activate", nm_activate, 1'b0);
    chk("mid_rst_done", op_done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_check(0, 1'b0);

    // controller stuck busy after the first activate
    stuck = 1;
    start_op(1'b0);
    wait_done(400, err);
    chk("tmo_err", err, 1'b1);
    @(negedge clk);
    in_win = (done_cyc - act_cyc) >= TMO && (done_cyc - act_cyc) <= TMO + 3;
    chk("tmo_latency", in_win, 1'b1);
    chk("tmo_idle", op_busy, 1'b0);
    stuck = 0;
    repeat (10) @(negedge clk);
    init_check("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
